// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-supply side of the nextIns / instructions handshake used by the
// multi-cycle control FSM. A start pulse begins execution at START_ADDR. Each
// nextIns pulse advances the program counter, either sequentially or to a
// taken branch target. The block then reads the next word from an instruction
// memory with a fixed read latency of MEM_LAT cycles. The opcode and operand
// are held stable until the control FSM asks for the following instruction.
//
// Ports:
//   clock         system clock, all state changes on the rising edge
//   resetN        asynchronous active-low reset
//   start         single-cycle pulse, (re)starts execution at START_ADDR
//   nextIns       request for the next instruction from the control FSM
//   branchEn      sampled with nextIns, 1 = next PC is branchTarget
//   branchTarget  branch destination address
//   imemAddr      instruction-memory read address (registered)
//   imemRdata     instruction-memory read data, valid MEM_LAT cycles after
//                 the address is presented
//   instructions  current opcode (top three bits of the fetched word)
//   operand       current operand field (remaining low bits)
//   insValid      instructions/operand hold a freshly fetched word
//   pc            address of the current or in-flight instruction
//   done          program has executed LAST_ADDR and stopped
//   seqErr        sticky flag for out-of-protocol start/nextIns requests
//
// All outputs are registered. There is no combinational path from any input
// to any output.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 9,
  parameter int MEM_LAT    = 1,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 255
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  input  logic               nextIns,
  input  logic               branchEn,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic [INSTR_W-1:0] imemRdata,
  output logic [2:0]         instructions,
  output logic [INSTR_W-4:0] operand,
  output logic               insValid,
  output logic [ADDR_W-1:0]  pc,
  output logic               done,
  output logic               seqErr
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);
  // MEM_LAT is limited to 1..3, so a two-bit down-counter is sufficient.
  localparam logic [1:0]        CNT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] lat_cnt;

  // Sequential successor. The increment wraps modulo 2^ADDR_W. Termination at
  // LAST_PC is checked before this is used, so the wrap matters only when
  // LAST_PC is not the all-ones address.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] cur);
    return cur + 1'b1;
  endfunction

  // Opcode is the top three bits of the word. The operand is everything below.
  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 3];
  endfunction

  function automatic logic [INSTR_W-4:0] operand_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-4:0];
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      pc           <= START_PC;
      imemAddr     <= START_PC;
      instructions <= '0;
      operand      <= '0;
      insValid     <= 1'b0;
      done         <= 1'b0;
      seqErr       <= 1'b0;
    end else begin
      case (state)
        // Idle after reset: only start matters. A stray nextIns here is
        // silently ignored and is not treated as a protocol error.
        S_IDLE: begin
          if (start) begin
            pc       <= START_PC;
            imemAddr <= START_PC;
            state    <= S_ISSUE;
          end
        end

        // imemAddr already carries pc for this cycle. Arm the latency counter.
        // With MEM_LAT == 1 the counter starts at zero, so WAIT captures on its
        // first cycle.
        S_ISSUE: begin
          if (start || nextIns) begin
            seqErr <= 1'b1;
          end
          lat_cnt <= CNT_INIT;
          state   <= S_WAIT;
        end

        // Read in flight. Capture the word once the counter has run out.
        S_WAIT: begin
          if (start || nextIns) begin
            seqErr <= 1'b1;
          end
          if (lat_cnt == 2'd0) begin
            instructions <= opcode_of(imemRdata);
            operand      <= operand_of(imemRdata);
            insValid     <= 1'b1;
            state        <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        // Instruction presented. If start and nextIns arrive together,
        // nextIns is still serviced and start is only flagged as an error.
        // instructions/operand keep their old value until the next capture.
        S_HOLD: begin
          if (start) begin
            seqErr <= 1'b1;
          end
          if (nextIns) begin
            insValid <= 1'b0;
            if (branchEn) begin
              // A taken branch wins even at LAST_PC, so it never terminates.
              pc       <= branchTarget;
              imemAddr <= branchTarget;
              state    <= S_ISSUE;
            end else if (pc == LAST_PC) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc       <= pc_incr(pc);
              imemAddr <= pc_incr(pc);
              state    <= S_ISSUE;
            end
          end
        end

        // Program finished. pc stays on the last instruction until a restart.
        S_DONE: begin
          if (nextIns) begin
            seqErr <= 1'b1;
          end
          if (start) begin
            pc       <= START_PC;
            imemAddr <= START_PC;
            done     <= 1'b0;
            state    <= S_ISSUE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch with two instances.
//   u_dut1 : MEM_LAT=1, LAST_ADDR=3   (sequential run, branch, end/restart)
//   u_dut3 : MEM_LAT=3, LAST_ADDR=255 (latency, nextIns in WAIT, mid-fetch
//            reset)
// Each instance is fed by its own memory model. The model delays data by the
// read latency of that instance.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  int npass = 0;
  int ntotal = 0;

  // ---------------- instance 1 : MEM_LAT=1, LAST_ADDR=3 ----------------
  logic       st1 = 1'b0, ni1 = 1'b0, be1 = 1'b0;
  logic [7:0] bt1 = 8'h00;
  logic [7:0] ia1, pc1;
  logic [8:0] rd1;
  logic [2:0] ins1;
  logic [5:0] opd1;
  logic       v1, dn1, se1;
  logic [8:0] mem1 [256];

  instr_fetch #(.ADDR_W(8), .INSTR_W(9), .MEM_LAT(1), .START_ADDR(0), .LAST_ADDR(3)) u_dut1 (
    .clock(clock), .resetN(resetN), .start(st1), .nextIns(ni1), .branchEn(be1),
    .branchTarget(bt1), .imemAddr(ia1), .imemRdata(rd1), .instructions(ins1),
    .operand(opd1), .insValid(v1), .pc(pc1), .done(dn1), .seqErr(se1));

  always_ff @(posedge clock) rd1 <= mem1[ia1];

  // ---------------- instance 3 : MEM_LAT=3, LAST_ADDR=255 ----------------
  logic       st3 = 1'b0, ni3 = 1'b0, be3 = 1'b0;
  logic [7:0] bt3 = 8'h00;
  logic [7:0] ia3, pc3;
  logic [8:0] rd3, m3_p0, m3_p1;
  logic [2:0] ins3;
  logic [5:0] opd3;
  logic       v3, dn3, se3;
  logic [8:0] mem3 [256];

  instr_fetch #(.ADDR_W(8), .INSTR_W(9), .MEM_LAT(3), .START_ADDR(0), .LAST_ADDR(255)) u_dut3 (
    .clock(clock), .resetN(resetN), .start(st3), .nextIns(ni3), .branchEn(be3),
    .branchTarget(bt3), .imemAddr(ia3), .imemRdata(rd3), .instructions(ins3),
    .operand(opd3), .insValid(v3), .pc(pc3), .done(dn3), .seqErr(se3));

  always_ff @(posedge clock) begin
    m3_p0 <= mem3[ia3];
    m3_p1 <= m3_p0;
    rd3   <= m3_p1;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hand-written expected words for dut1 addresses 0..3 (opcode, operand).
  logic [2:0] exp_op  [4];
  logic [5:0] exp_opd [4];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 9'h000;
      mem3[i] = 9'h000;
    end
    mem1[0]  = 9'b010_000101;
    mem1[1]  = 9'b101_110011;
    mem1[2]  = 9'b111_000001;
    mem1[3]  = 9'b001_111110;
    mem1[16] = 9'b110_101010;
    mem3[0]  = 9'b100_011001;
    mem3[1]  = 9'b011_100110;
    exp_op[0] = 3'b010; exp_opd[0] = 6'b000101;
    exp_op[1] = 3'b101; exp_opd[1] = 6'b110011;
    exp_op[2] = 3'b111; exp_opd[2] = 6'b000001;
    exp_op[3] = 3'b001; exp_opd[3] = 6'b111110;

    // ---------------- reset ----------------
    tick(); tick(); tick();
    chk("rst_pc", pc1, 0);
    chk("rst_imemAddr", ia1, 0);
    chk("rst_instr", ins1, 0);
    chk("rst_operand", opd1, 0);
    chk("rst_insValid", v1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_seqErr", se1, 0);
    resetN = 1'b1;
    tick();

    // nextIns in IDLE is ignored without error
    ni1 = 1'b1; tick(); ni1 = 1'b0;
    chk("idle_nextIns_seqErr", se1, 0);
    chk("idle_nextIns_valid", v1, 0);

    // ---------------- first fetch, MEM_LAT=1 ----------------
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("start_imemAddr", ia1, 0);
    chk("start_valid_c1", v1, 0);
    tick();
    chk("start_valid_c2pre", v1, 0);
    tick();
    chk("start_valid", v1, 1);
    chk("start_instr", ins1, 3'b010);
    chk("start_operand", opd1, 6'b000101);
    chk("start_pc", pc1, 0);
    tick();
    chk("hold0_instr", ins1, 3'b010);

    // ---------------- sequential run, nextIns every 4 cycles ----------------
    for (int k = 1; k < 4; k++) begin
      ni1 = 1'b1; tick(); ni1 = 1'b0;
      chk("seq_valid_low1", v1, 0);
      chk("seq_pc", pc1, k);
      chk("seq_imemAddr", ia1, k);
      chk("seq_old_instr", ins1, exp_op[k-1]);
      tick();
      chk("seq_valid_low2", v1, 0);
      tick();
      chk("seq_valid_high", v1, 1);
      chk("seq_instr", ins1, exp_op[k]);
      chk("seq_operand", opd1, exp_opd[k]);
      tick();
      chk("seq_hold_instr", ins1, exp_op[k]);
      chk("seq_hold_pc", pc1, k);
    end

    // ---------------- end of program ----------------
    ni1 = 1'b1; tick(); ni1 = 1'b0;
    chk("end_done", dn1, 1);
    chk("end_valid", v1, 0);
    chk("end_pc", pc1, 3);
    chk("end_seqErr_clean", se1, 0);
    tick();
    ni1 = 1'b1; tick(); ni1 = 1'b0;
    chk("done_nextIns_seqErr", se1, 1);
    chk("done_nextIns_pc", pc1, 3);
    chk("done_nextIns_done", dn1, 1);

    // ---------------- restart ----------------
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("restart_done", dn1, 0);
    chk("restart_pc", pc1, 0);
    chk("restart_imemAddr", ia1, 0);
    tick(); tick();
    chk("restart_valid", v1, 1);
    chk("restart_instr", ins1, 3'b010);

    // advance to pc=2
    ni1 = 1'b1; tick(); ni1 = 1'b0; tick(); tick();
    ni1 = 1'b1; tick(); ni1 = 1'b0; tick(); tick();
    chk("pre_branch_pc", pc1, 2);
    chk("pre_branch_instr", ins1, 3'b111);

    // ---------------- branch ----------------
    ni1 = 1'b1; be1 = 1'b1; bt1 = 8'h10; tick(); ni1 = 1'b0; be1 = 1'b0;
    chk("branch_imemAddr", ia1, 8'h10);
    chk("branch_pc", pc1, 8'h10);
    chk("branch_valid_low", v1, 0);
    tick(); tick();
    chk("branch_valid", v1, 1);
    chk("branch_instr", ins1, 3'b110);
    chk("branch_operand", opd1, 6'b101010);

    // branchEn without nextIns: no effect
    be1 = 1'b1; bt1 = 8'h40; tick(); tick(); be1 = 1'b0;
    chk("lone_branch_pc", pc1, 8'h10);
    chk("lone_branch_imemAddr", ia1, 8'h10);
    chk("lone_branch_valid", v1, 1);

    // ---------------- MEM_LAT=3 ----------------
    chk("lat3_seqErr_clean", se3, 0);
    st3 = 1'b1; tick(); st3 = 1'b0;
    chk("lat3_imemAddr", ia3, 0);
    tick();
    chk("lat3_valid_c2", v3, 0);
    ni3 = 1'b1; tick(); ni3 = 1'b0;  // nextIns while in WAIT
    chk("lat3_wait_seqErr", se3, 1);
    chk("lat3_wait_pc", pc3, 0);
    chk("lat3_valid_c3", v3, 0);
    tick();
    chk("lat3_valid_c4pre", v3, 0);
    tick();
    chk("lat3_valid", v3, 1);
    chk("lat3_instr", ins3, 3'b100);
    chk("lat3_operand", opd3, 6'b011001);
    chk("lat3_pc", pc3, 0);

    // ---------------- mid-fetch asynchronous reset ----------------
    ni3 = 1'b1; tick(); ni3 = 1'b0;
    chk("lat3_next_pc", pc3, 1);
    tick(); tick();                  // now in WAIT with mem3[1] in flight
    #2 resetN = 1'b0;
    #1;
    chk("arst_pc", pc3, 0);
    chk("arst_imemAddr", ia3, 0);
    chk("arst_instr", ins3, 0);
    chk("arst_operand", opd3, 0);
    chk("arst_valid", v3, 0);
    chk("arst_seqErr", se3, 0);
    chk("arst_done", dn3, 0);
    chk("arst_dut1_pc", pc1, 0);
    tick(); tick();
    resetN = 1'b1;
    tick(); tick(); tick(); tick();
    chk("post_rst_no_capture", v3, 0);
    chk("post_rst_instr", ins3, 0);
    st3 = 1'b1; tick(); st3 = 1'b0;
    chk("refetch_imemAddr", ia3, 0);
    tick(); tick(); tick();
    chk("refetch_valid_pre", v3, 0);
    tick();
    chk("refetch_valid", v3, 1);
    chk("refetch_instr", ins3, 3'b100);
    chk("refetch_operand", opd3, 6'b011001);
    chk("refetch_pc", pc3, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-supply end of the `nextIns` / `instructions` interface of the multi-cycle control FSM.
- On each `nextIns` pulse it advances the program counter and reads the next instruction word from instruction memory, which has a fixed read latency.
- It holds the opcode and operand stable until the control FSM requests the next instruction.
- It handles taken branches, end-of-program detection and protocol-violation flagging.

Parameters:
- ADDR_W, 8, program-counter and instruction-memory address width.
- INSTR_W, 9, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-3].
- MEM_LAT, 1, instruction-memory read latency in cycles, legal 1..3.
- START_ADDR, 0, PC value after reset and on each `start`.
- LAST_ADDR, 255, address of the final program instruction.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins execution from START_ADDR.
- nextIns  in  1  request for the next instruction, from the control FSM.
- branchEn  in  1  sampled with `nextIns`; 1 = load `branchTarget` into the PC.
- branchTarget  in  ADDR_W  branch destination address.
- imemAddr  out  ADDR_W  instruction-memory read address.
- imemRdata  in  INSTR_W  instruction-memory read data, valid MEM_LAT cycles after the address.
- instructions  out  3  current opcode, to the control FSM.
- operand  out  INSTR_W-3  current operand field.
- insValid  out  1  opcode and operand hold a fetched instruction.
- pc  out  ADDR_W  address of the current or in-flight instruction.
- done  out  1  program finished.
- seqErr  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, resetN=0, any time including mid-fetch):
  - state=IDLE, pc=START_ADDR, imemAddr=START_ADDR.
  - instructions=0, operand=0, insValid=0, done=0, seqErr=0.
  - Latency counter cleared; any in-flight read is discarded.
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - `start` leads to ISSUE; `nextIns` is ignored and does not set seqErr.
- ISSUE:
  - imemAddr=pc for one cycle.
  - Load latency counter with MEM_LAT-1, then go to WAIT, or directly to capture when MEM_LAT=1.
- WAIT:
  - Decrement the counter each cycle.
  - At count 0, register imemRdata: opcode to `instructions`, low bits to `operand`, insValid<=1, go to HOLD.
- Fetch latency:
  - `start` sampled at edge N gives insValid=1 after edge N+1+MEM_LAT.
  - `nextIns` to the next insValid is likewise 1+MEM_LAT cycles.
- HOLD:
  - instructions, operand and pc stay stable indefinitely.
  - On `nextIns`: insValid<=0; instructions and operand keep their old values until the next capture.
  - If branchEn=1: pc<=branchTarget, go to ISSUE.
  - Else if pc==LAST_ADDR: go to DONE, pc unchanged.
  - Else: pc<=pc+1, go to ISSUE.
- PC arithmetic:
  - Increment is modulo 2^ADDR_W, but reaching LAST_ADDR always terminates first.
  - A branch from LAST_ADDR is taken and does not terminate.
- DONE:
  - done=1 and insValid=0.
  - `start` sets pc<=START_ADDR, done<=0, and goes to ISSUE.
- seqErr (sticky until reset) is set by:
  - `nextIns` in ISSUE, WAIT or DONE;
  - `start` in ISSUE, WAIT or HOLD.
  - The offending request is otherwise ignored, with no state or pc change.
- Simultaneous events:
  - `start` and `nextIns` in the same cycle in HOLD: `nextIns` is serviced and seqErr is set.
  - branchEn without `nextIns` has no effect.
- imemAddr: holds the last issued address outside ISSUE. No combinational path from any input to any output.

Test Plan:
- Reset, then `start` with MEM_LAT=1 and memory[0]=9'b010_000101: insValid=1 two cycles after `start`; instructions=3'b010, operand=6'b000101, pc=0.
- Sequential run:
  - Stimulus: pulse `nextIns` every 4 cycles, matching the control FSM cadence, over memory[0..3].
  - Required: pc steps 0,1,2,3; each opcode stable through its HOLD period; insValid low for exactly 2 cycles after each pulse.
- Branch:
  - Stimulus: at pc=2, `nextIns` with branchEn=1 and branchTarget=8'h10.
  - Required: imemAddr=8'h10 on the next cycle; the new instruction is from 8'h10; pc=8'h10.
- End and restart:
  - Stimulus: LAST_ADDR=3; `nextIns` at pc=3.
  - Required: done=1, insValid=0.
  - Stimulus: `nextIns` in DONE. Required: seqErr=1, pc=3.
  - Stimulus: `start`. Required: done=0, pc=0, fetch resumes.
- MEM_LAT=3:
  - Required: insValid rises 4 cycles after `start`.
  - Stimulus: `nextIns` during WAIT. Required: seqErr=1, fetch completes unaffected.
- Mid-fetch reset:
  - Stimulus: drop resetN during WAIT.
  - Required: all outputs return to reset values immediately, asynchronously; after release, no stale capture occurs and `start` refetches START_ADDR.
